mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IFU/LSU arbiter onto one combinational memory port
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_addr,
    output logic        if_resp_valid,
    input  logic        if_resp_ready,
    output logic [63:0] if_rdata,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [63:0] ls_addr,
    input  logic        ls_we,
    input  logic [63:0] ls_wdata,
    input  logic [7:0]  ls_wmask,
    output logic        ls_resp_valid,
    input  logic        ls_resp_ready,
    output logic [63:0] ls_rdata,
    output logic [63:0] mem_addr,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RESP_IF = 2'd2;
    localparam logic [1:0] ST_RESP_LS = 2'd3;

    logic [1:0]  r_state;
    logic [3:0]  r_starve;
    logic        r_rst_d;
    logic        r_owner_ls;
    logic [63:0] r_addr;
    logic        r_we;
    logic [63:0] r_wdata;
    logic [7:0]  r_wmask;
    logic [63:0] r_rdata;

    logic w_out_en;
    logic w_idle;
    logic w_access;
    logic w_starved;
    logic w_grant_if;
    logic w_grant_ls;
    logic w_if_hs;
    logic w_ls_hs;

    // Outputs stay quiet while reset is high and for one cycle after it drops.
    assign w_out_en   = !reset && !r_rst_d;
    assign w_idle     = (r_state == ST_IDLE) && w_out_en;
    assign w_access   = (r_state == ST_ACCESS) && w_out_en;
    assign w_starved  = (r_starve == 4'(STARVE_LIMIT));
    assign w_grant_if = if_req_valid && (!ls_req_valid || w_starved);
    assign w_grant_ls = ls_req_valid && !w_grant_if;

    assign if_req_ready = w_idle && w_grant_if;
    assign ls_req_ready = w_idle && w_grant_ls;
    assign w_if_hs      = if_req_valid && if_req_ready;
    assign w_ls_hs      = ls_req_valid && ls_req_ready;

    assign mem_ce    = w_access;
    assign mem_addr  = w_access ? r_addr  : '0;
    assign mem_we    = w_access ? r_we    : 1'b0;
    assign mem_wdata = w_access ? r_wdata : '0;
    assign mem_wmask = w_access ? r_wmask : '0;

    assign if_resp_valid = (r_state == ST_RESP_IF) && w_out_en;
    assign ls_resp_valid = (r_state == ST_RESP_LS) && w_out_en;
    assign if_rdata      = if_resp_valid ? r_rdata : '0;
    assign ls_rdata      = ls_resp_valid ? r_rdata : '0;

    always_ff @(posedge clk) begin
        r_rst_d <= reset;
        if (reset) begin
            r_state    <= ST_IDLE;
            r_starve   <= '0;
            r_owner_ls <= 1'b0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_if_hs) begin
                        r_addr     <= if_addr;
                        r_we       <= 1'b0;
                        r_wdata    <= '0;
                        r_wmask    <= '0;
                        r_owner_ls <= 1'b0;
                        r_starve   <= '0;
                        r_state    <= ST_ACCESS;
                    end else if (w_ls_hs) begin
                        r_addr     <= ls_addr;
                        r_we       <= ls_we;
                        r_wdata    <= ls_wdata;
                        r_wmask    <= ls_wmask;
                        r_owner_ls <= 1'b1;
                        r_state    <= ST_ACCESS;
                        if (!if_req_valid)
                            r_starve <= '0;
                        else if (!w_starved)
                            r_starve <= r_starve + 4'd1;
                    end else if (!if_req_valid) begin
                        r_starve <= '0;
                    end
                end
                ST_ACCESS: begin
                    r_rdata <= r_we ? '0 : mem_rdata;
                    r_state <= r_owner_ls ? ST_RESP_LS : ST_RESP_IF;
                end
                ST_RESP_IF: begin
                    if (if_resp_valid && if_resp_ready)
                        r_state <= ST_IDLE;
                end
                ST_RESP_LS: begin
                    if (ls_resp_valid && ls_resp_ready)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
